// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding, count width and default timing for the
// reset sequencer.
package rst_seq_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RECOVER, S_DONE} state_t;
    localparam int CNT_W = 8;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ASSERT_CYCLES = 3;
    localparam int DEF_RECOVERY_CYCLES = 4;
endpackage

// File: rtl/rst_seq_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or
// after the pointer, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] pointer,
    output logic         valid,
    output logic [W-1:0] idx
);
    logic [W-1:0] j;
    // Walk from farthest to nearest so the nearest requester wins last.
    always_comb begin
        valid = 1'b0;
        idx = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = W'((int'(pointer) + i) % N);
            if (req[j]) begin
                valid = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: round-robin peripheral reset sequencer (assert, recover, ack).
// Define RST_SEQ_CTRL_POR_EN to run one un-acked power-on sequence after preset.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
    parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       periph_rst_n_o,
    output logic [CNT_W-1:0]           rst_count_o
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int MAXC = ASSERT_CYCLES > RECOVERY_CYCLES ? ASSERT_CYCLES : RECOVERY_CYCLES;
    localparam int PW = $clog2(MAXC + 1);
    localparam logic [PW-1:0] A_LD = PW'(ASSERT_CYCLES - 1);
    localparam logic [PW-1:0] R_LD = PW'(RECOVERY_CYCLES - 1);
`ifdef RST_SEQ_CTRL_POR_EN
    localparam state_t RST_STATE = S_ASSERT;
    localparam logic RST_POR = 1'b1;
`else
    localparam state_t RST_STATE = S_IDLE;
    localparam logic RST_POR = 1'b0;
`endif

    state_t state, next_state;
    logic [PW-1:0] phase;
    logic [GW-1:0] pointer, gnt_idx;
    logic gnt_valid, por;

    rr_arbiter #(.N(NUM_REQ), .W(GW)) u_arb (
        .req     (req_i),
        .pointer (pointer),
        .valid   (gnt_valid),
        .idx     (gnt_idx)
    );

    always_ff @(posedge pclk or posedge preset)
        if (preset) state <= RST_STATE;
        else state <= next_state;

    always_comb
        next_state = state == S_IDLE    ? (gnt_valid ? S_ASSERT : S_IDLE) :
                     state == S_ASSERT  ? (phase == '0 ? S_RECOVER : S_ASSERT) :
                     state == S_RECOVER ? (phase == '0 ? S_DONE : S_RECOVER) : S_IDLE;

    // The power-on sequence has no owner, so it is never acked or counted.
    always_comb
        ack_o = (state == S_DONE && !por) ? NUM_REQ'(1) << grant_id_o : '0;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            phase <= A_LD;
            pointer <= '0;
            grant_id_o <= '0;
            rst_count_o <= '0;
            periph_rst_n_o <= 1'b0;
            busy_o <= 1'b1;
            por <= RST_POR;
        end else begin
            periph_rst_n_o <= next_state != S_ASSERT;
            busy_o <= next_state != S_IDLE;
            phase <= (next_state == S_ASSERT && state != S_ASSERT) ? A_LD :
                     (next_state == S_RECOVER && state != S_RECOVER) ? R_LD :
                     phase != '0 ? phase - PW'(1) : phase;
            if (state == S_IDLE && gnt_valid) begin
                grant_id_o <= gnt_idx;
                pointer <= gnt_idx == GW'(NUM_REQ - 1) ? '0 : gnt_idx + GW'(1);
                por <= 1'b0;
            end
            if (state == S_DONE && !por && rst_count_o != '1)
                rst_count_o <= rst_count_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed scoreboard bench for rst_seq_ctrl; a monitor pops
// expected acks whenever ack_o is non-zero.
module tb_rst_seq_ctrl;
    localparam int N = 4, A = 3, R = 4, SEQ = A + R + 2;
    typedef struct {logic [N-1:0] ack; int cyc;} exp_t;

    logic pclk = 1'b0, preset = 1'b1;
    logic [N-1:0] req_i = '0, ack_o;
    logic [1:0] grant_id_o;
    logic busy_o, periph_rst_n_o;
    logic [7:0] rst_count_o;
    int checks = 0, errors = 0, cyc = 0, acks_seen = 0, n = 0;
    exp_t sb[$];

    rst_seq_ctrl #(.NUM_REQ(N), .ASSERT_CYCLES(A), .RECOVERY_CYCLES(R)) dut (
        .pclk           (pclk),
        .preset         (preset),
        .req_i          (req_i),
        .ack_o          (ack_o),
        .grant_id_o     (grant_id_o),
        .busy_o         (busy_o),
        .periph_rst_n_o (periph_rst_n_o),
        .rst_count_o    (rst_count_o)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk or posedge preset) cyc <= preset ? 0 : cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // An ack issued by sequence granted at edge g appears after edge g+A+R.
    task automatic push(input logic [N-1:0] ack, input int c);
        exp_t e;
        e.ack = ack;
        e.cyc = c;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (!preset && ack_o != '0) begin
                acks_seen++;
                if (sb.size() == 0) chk("unexpected_ack", int'(ack_o), 0);
                else begin
                    e = sb.pop_front();
                    chk("ack_value", int'(ack_o), int'(e.ack));
                    if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_acks(input int target, input int budget, input bit drop);
        int k = 0;
        while (acks_seen < target && k < budget) begin
            @(negedge pclk);
            if (drop) req_i = req_i & ~ack_o;
            k++;
        end
        chk("ack_count", acks_seen, target);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy_o && k < budget) begin
            @(negedge pclk);
            k++;
        end
        chk("idle_timeout", int'(busy_o), 0);
    endtask

    task automatic release_check();
`ifdef RST_SEQ_CTRL_POR_EN
        int low = 0;
        for (int i = 0; i < 40 && busy_o; i++) begin
            if (!periph_rst_n_o) low++;
            @(negedge pclk);
        end
        chk("por_low_cycles", low, A);
        chk("por_count", int'(rst_count_o), 0);
`else
        @(negedge pclk);
        chk("rel_periph", int'(periph_rst_n_o), 1);
        chk("rel_busy", int'(busy_o), 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge pclk);
        preset = 1'b1;
        req_i = '0;
        #1;
        chk("rst_periph", int'(periph_rst_n_o), 0);
        chk("rst_busy", int'(busy_o), 1);
        chk("rst_ack", int'(ack_o), 0);
        chk("rst_grant", int'(grant_id_o), 0);
        chk("rst_count", int'(rst_count_o), 0);
        @(negedge pclk);
        preset = 1'b0;
        release_check();
    endtask

    initial begin
        do_reset();
        // Single request, withdrawn right after grant: must still complete.
        req_i = 4'b0010;
        n = cyc + 1;
        push(4'b0010, n + A + R);
        for (int k = 0; k <= A; k++) begin
            @(negedge pclk);
            if (k == 0) begin
                req_i = '0;
                chk("t1_grant", int'(grant_id_o), 1);
            end
            chk("t1_periph", int'(periph_rst_n_o), k < A ? 0 : 1);
        end
        wait_acks(1, 40, 1'b1);
        wait_idle(10);
        chk("t1_count", int'(rst_count_o), 1);
        // Pointer is now 2: requests 0 and 1 wrap to 0 first, then 1.
        @(negedge pclk);
        req_i = 4'b0011;
        n = cyc + 1;
        push(4'b0001, n + A + R);
        push(4'b0010, n + SEQ + A + R);
        wait_acks(3, 60, 1'b1);
        wait_idle(10);
        chk("t2_count", int'(rst_count_o), 3);
        do_reset();
        // All four requesting from pointer 0.
        req_i = 4'b1111;
        n = cyc + 1;
        for (int k = 0; k < N; k++) push(N'(1) << k, n + k * SEQ + A + R);
        wait_acks(7, 100, 1'b1);
        wait_idle(10);
        chk("t4_count", int'(rst_count_o), 4);
        // Abort requester 3 mid-assert: no ack, count cleared.
        @(negedge pclk);
        req_i = 4'b1000;
        @(negedge pclk);
        chk("t5_grant", int'(grant_id_o), 3);
        chk("t5_periph", int'(periph_rst_n_o), 0);
        preset = 1'b1;
        #1;
        chk("t5_rst_periph", int'(periph_rst_n_o), 0);
        chk("t5_rst_ack", int'(ack_o), 0);
        chk("t5_rst_count", int'(rst_count_o), 0);
        @(negedge pclk);
        preset = 1'b0;
        req_i = '0;
        repeat (20) @(negedge pclk);
        wait_idle(20);
        chk("t5_acks", acks_seen, 7);
        chk("t5_count", int'(rst_count_o), 0);
        // 256 back-to-back sequences saturate the counter.
        req_i = 4'b0001;
        for (int k = 0; k < 256; k++) push(4'b0001, -1);
        wait_acks(7 + 256, 256 * SEQ + 50, 1'b0);
        req_i = '0;
        wait_idle(20);
        chk("t6_count_sat", int'(rst_count_o), 255);
        repeat (12) @(negedge pclk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
